// File: rtl/gray_counter_ud_if.sv
// Control and status bundle for gray_counter_ud; Terminal is present only with GRAY_CNT_TERM_EN.
// The master drives the step/load/clear controls; the slave (the counter) returns the registered count and flags.
interface gray_counter_ud_if #(
    parameter int WIDTH = 3
);
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             Clear;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Binary;
    logic             Overflow;
    logic             Underflow;
`ifdef GRAY_CNT_TERM_EN
    logic             Terminal;

    modport master (
        output En, Up, Load, LoadVal, Clear,
        input  Output, Binary, Overflow, Underflow, Terminal
    );
    modport slave (
        input  En, Up, Load, LoadVal, Clear,
        output Output, Binary, Overflow, Underflow, Terminal
    );
`else
    modport master (
        output En, Up, Load, LoadVal, Clear,
        input  Output, Binary, Overflow, Underflow
    );
    modport slave (
        input  En, Up, Load, LoadVal, Clear,
        output Output, Binary, Overflow, Underflow
    );
`endif
endinterface

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with load, wrap/saturate, sticky flags; optional Terminal via GRAY_CNT_TERM_EN.
// Latency: one edge from En/Load/Clear to Output, Binary and flags; all outputs registered.
// Backpressure: none; every enabled edge takes exactly one step, Load has priority over En.
module gray_counter_ud #(
    parameter int          WIDTH = 3,
    parameter bit          WRAP  = 1'b1,
    parameter int unsigned INIT  = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    gray_counter_ud_if.slave  cnt
);
    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_G = INIT_B ^ (INIT_B >> 1);
    localparam logic [WIDTH-1:0] MAXV   = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] lv_bin;
    logic             ov;
    logic             ov_nxt;
    logic             un;
    logic             un_nxt;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        lv_bin            = '0;
        lv_bin[WIDTH-1]   = cnt.LoadVal[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            lv_bin[i] = lv_bin[i+1] ^ cnt.LoadVal[i];
        end
    end

    always_comb begin
        b_nxt  = b;
        ov_nxt = ov & ~cnt.Clear;
        un_nxt = un & ~cnt.Clear;
        if (cnt.Load) begin
            b_nxt = lv_bin;
        end else if (cnt.En && cnt.Up) begin
            if (b == MAXV) begin
                ov_nxt = 1'b1;
                if (WRAP) b_nxt = '0;
            end else begin
                b_nxt = b + ONE;
            end
        end else if (cnt.En) begin
            if (b == '0) begin
                un_nxt = 1'b1;
                if (WRAP) b_nxt = MAXV;
            end else begin
                b_nxt = b - ONE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            b  <= INIT_B;
            g  <= INIT_G;
            ov <= 1'b0;
            un <= 1'b0;
        end else begin
            b  <= b_nxt;
            g  <= b_nxt ^ (b_nxt >> 1);
            ov <= ov_nxt;
            un <= un_nxt;
        end
    end

    assign cnt.Output    = g;
    assign cnt.Binary    = b;
    assign cnt.Overflow  = ov;
    assign cnt.Underflow = un;

`ifdef GRAY_CNT_TERM_EN
    logic dir;
    logic dir_nxt;
    logic term;
    logic term_nxt;

    // Terminal flags the state one step before the end of the range, so the
    // registered output warns a cycle ahead of the wrap or saturation.
    always_comb begin
        dir_nxt  = (cnt.Load || cnt.En) ? cnt.Up : dir;
        term_nxt = dir_nxt ? (b_nxt == (MAXV - ONE)) : (b_nxt == ONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir  <= 1'b1;
            term <= 1'b0;
        end else begin
            dir  <= dir_nxt;
            term <= term_nxt;
        end
    end

    assign cnt.Terminal = term;
`endif
endmodule

// File: tb/tb_gray_counter_ud.sv
// Directed, table-driven bench for gray_counter_ud: three instances (3-bit wrap, 3-bit saturate INIT=5, 4-bit wrap).
module tb_gray_counter_ud;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] ld    = 4'h0;
    logic       clr   = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gray_counter_ud_if #(.WIDTH(3)) ifa ();
    gray_counter_ud_if #(.WIDTH(3)) ifb ();
    gray_counter_ud_if #(.WIDTH(4)) ifc ();

    assign ifa.En = en;  assign ifa.Up = up;  assign ifa.Load = load;  assign ifa.LoadVal = ld[2:0];  assign ifa.Clear = clr;
    assign ifb.En = en;  assign ifb.Up = up;  assign ifb.Load = load;  assign ifb.LoadVal = ld[2:0];  assign ifb.Clear = clr;
    assign ifc.En = en;  assign ifc.Up = up;  assign ifc.Load = load;  assign ifc.LoadVal = ld;       assign ifc.Clear = clr;

    gray_counter_ud #(.WIDTH(3), .WRAP(1'b1), .INIT(0)) u_a (.Clk(clk), .Reset_n(rst_n), .cnt(ifa));
    gray_counter_ud #(.WIDTH(3), .WRAP(1'b0), .INIT(5)) u_b (.Clk(clk), .Reset_n(rst_n), .cnt(ifb));
    gray_counter_ud #(.WIDTH(4), .WRAP(1'b1), .INIT(0)) u_c (.Clk(clk), .Reset_n(rst_n), .cnt(ifc));

    typedef struct {
        logic       en, up, load;
        logic [3:0] ld;
        logic       clr;
        logic [2:0] out, bin;
        logic       ov, un;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic e, logic u, logic l, logic [3:0] v, logic c,
                                logic [2:0] o, logic [2:0] bi, logic f_ov, logic f_un);
        vec_t r;
        r.en = e; r.up = u; r.load = l; r.ld = v; r.clr = c;
        r.out = o; r.bin = bi; r.ov = f_ov; r.un = f_un;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] v, input logic c);
        en = e; up = u; load = l; ld = v; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en up ld  ldval  clr | out     bin  ov un
        tbl[0]  = mk(1, 1, 0, 4'h0, 0, 3'b001, 3'd1, 0, 0);
        tbl[1]  = mk(1, 1, 0, 4'h0, 0, 3'b011, 3'd2, 0, 0);
        tbl[2]  = mk(1, 1, 0, 4'h0, 0, 3'b010, 3'd3, 0, 0);
        tbl[3]  = mk(1, 1, 0, 4'h0, 0, 3'b110, 3'd4, 0, 0);
        tbl[4]  = mk(1, 1, 0, 4'h0, 0, 3'b111, 3'd5, 0, 0);
        tbl[5]  = mk(1, 1, 0, 4'h0, 0, 3'b101, 3'd6, 0, 0);
        tbl[6]  = mk(1, 1, 0, 4'h0, 0, 3'b100, 3'd7, 0, 0);
        tbl[7]  = mk(1, 1, 0, 4'h0, 0, 3'b000, 3'd0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 4'h0, 1, 3'b000, 3'd0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 4'h0, 0, 3'b100, 3'd7, 0, 1);
        tbl[10] = mk(0, 0, 0, 4'h0, 1, 3'b100, 3'd7, 0, 0);
        tbl[11] = mk(1, 1, 0, 4'h0, 1, 3'b000, 3'd0, 1, 0);
        tbl[12] = mk(1, 1, 1, 4'h3, 0, 3'b011, 3'd2, 1, 0);
        tbl[13] = mk(0, 0, 1, 4'h3, 0, 3'b011, 3'd2, 1, 0);
        tbl[14] = mk(1, 1, 0, 4'h0, 0, 3'b010, 3'd3, 1, 0);
        tbl[15] = mk(1, 0, 0, 4'h0, 0, 3'b011, 3'd2, 1, 0);
        tbl[16] = mk(1, 0, 0, 4'h0, 0, 3'b001, 3'd1, 1, 0);
        tbl[17] = mk(1, 0, 0, 4'h0, 0, 3'b000, 3'd0, 1, 0);
        tbl[18] = mk(1, 0, 0, 4'h0, 0, 3'b100, 3'd7, 1, 1);

        // Reset values
        #12;
        check("rst_a_out", 32'(ifa.Output), 32'h0);
        check("rst_a_bin", 32'(ifa.Binary), 32'h0);
        check("rst_a_ov",  32'(ifa.Overflow), 32'h0);
        check("rst_a_un",  32'(ifa.Underflow), 32'h0);
        check("rst_b_out", 32'(ifb.Output), 32'h7);
        check("rst_b_bin", 32'(ifb.Binary), 32'h5);
`ifdef GRAY_CNT_TERM_EN
        check("rst_a_term", 32'(ifa.Terminal), 32'h0);
`endif
        #8;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].ld, tbl[i].clr);
            check($sformatf("vec%0d_out", i), 32'(ifa.Output), 32'(tbl[i].out));
            check($sformatf("vec%0d_bin", i), 32'(ifa.Binary), 32'(tbl[i].bin));
            check($sformatf("vec%0d_ov", i),  32'(ifa.Overflow), 32'(tbl[i].ov));
            check($sformatf("vec%0d_un", i),  32'(ifa.Underflow), 32'(tbl[i].un));
        end

        // 4-bit: Load wins over a simultaneous up-step, then count on from the loaded value
        step(1, 1, 1, 4'b1100, 0);
        check("c_load_bin", 32'(ifc.Binary), 32'd8);
        check("c_load_out", 32'(ifc.Output), 32'hC);
        step(1, 1, 0, 4'h0, 0);
        check("c_step_out", 32'(ifc.Output), 32'hD);
        check("c_step_bin", 32'(ifc.Binary), 32'd9);

        // Saturating instance held at the top
        step(0, 0, 1, 4'b0100, 0);
        check("b_load7_out", 32'(ifb.Output), 32'h4);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 4'h0, 0);
            check($sformatf("b_sat%0d_out", k), 32'(ifb.Output), 32'h4);
            check($sformatf("b_sat%0d_ov", k),  32'(ifb.Overflow), 32'h1);
        end
        step(1, 1, 0, 4'h0, 1);
        check("b_clr_vs_set_ov", 32'(ifb.Overflow), 32'h1);
        step(0, 0, 0, 4'h0, 1);
        check("b_clr_ov", 32'(ifb.Overflow), 32'h0);
        check("b_clr_un", 32'(ifb.Underflow), 32'h0);
        step(0, 0, 1, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        check("b_satlo_bin", 32'(ifb.Binary), 32'h0);
        check("b_satlo_un",  32'(ifb.Underflow), 32'h1);
        step(1, 0, 0, 4'h0, 1);
        check("b_satlo_clr_un", 32'(ifb.Underflow), 32'h1);
        check("b_satlo_out",    32'(ifb.Output), 32'h0);

        // Asynchronous reset mid-cycle with a flag set
        step(0, 0, 1, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        step(0, 0, 1, 4'h3, 0);
        check("pre_rst_a_out", 32'(ifa.Output), 32'h3);
        check("pre_rst_a_un",  32'(ifa.Underflow), 32'h1);
        en = 1'b0; load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_a_out", 32'(ifa.Output), 32'h0);
        check("arst_a_bin", 32'(ifa.Binary), 32'h0);
        check("arst_a_un",  32'(ifa.Underflow), 32'h0);
        check("arst_a_ov",  32'(ifa.Overflow), 32'h0);
        check("arst_b_out", 32'(ifb.Output), 32'h7);
        #3;
        rst_n = 1'b1;
        step(1, 1, 0, 4'h0, 0);
        check("post_rst_a_out", 32'(ifa.Output), 32'h1);

`ifdef GRAY_CNT_TERM_EN
        step(0, 1, 1, 4'b0111, 0);
        check("term_at5", 32'(ifa.Terminal), 32'h0);
        step(1, 1, 0, 4'h0, 0);
        check("term_at6_bin", 32'(ifa.Binary), 32'd6);
        check("term_at6", 32'(ifa.Terminal), 32'h1);
        step(1, 1, 0, 4'h0, 0);
        check("term_at7", 32'(ifa.Terminal), 32'h0);
        step(1, 1, 0, 4'h0, 0);
        check("term_at0", 32'(ifa.Terminal), 32'h0);
`endif

        step(0, 0, 0, 4'h0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
